box_tracker: RTL and testbench
==============================

BOX_TRACKER -- requirements
Module: box_tracker

Interface
REQ-001 Parameter SHIFT, default 2: EMA weight, new = old + (meas - old) >>> SHIFT.
REQ-002 Parameter MIN_AREA, default 64: minimum w*h for a measurement to count as a hit.
REQ-003 Parameter ACQ_FRAMES, default 3: consecutive hits required to lock.
REQ-004 Parameter LOST_FRAMES, default 8: consecutive misses while locked before the target is dropped.
REQ-005 Parameter MAX_JUMP, default 128: maximum per-axis centre displacement, in pixels (used only under REQ-025).
REQ-006 clk_in  input  1  pixel clock; single clock domain.
REQ-007 rst_n_in  input  1  asynchronous, active-low reset.
REQ-008 x_in  input  11  measured box left edge.
REQ-009 y_in  input  10  measured box top edge.
REQ-010 w_in  input  11  measured box width; 0 means no pixels found.
REQ-011 h_in  input  10  measured box height.
REQ-012 valid_in  input  1  one-cycle pulse per frame from the bounding-box stage qualifying x_in/y_in/w_in/h_in.
REQ-013 x_out, y_out, w_out, h_out  output  11/10/11/10  smoothed box.
REQ-014 locked_out  output  1  high in TRACK and COAST.
REQ-015 update_out  output  1  one-cycle pulse when a measurement has been processed.
REQ-016 state_out  output  2  IDLE=0, ACQUIRE=1, TRACK=2, COAST=3.

Function
REQ-017 Two-stage pipeline: stage 1 registers inputs and computes the 21-bit area w*h and hit = (w_in!=0) && (area>=MIN_AREA); stage 2 updates state and outputs. update_out pulses exactly 2 cycles after valid_in.
REQ-018 valid_in may assert on back-to-back cycles; every pulse is processed in order, with no stall.
REQ-019 IDLE: a hit loads the measurement directly into the outputs, sets hit count to 1 and moves to ACQUIRE; if ACQ_FRAMES==1 it moves directly to TRACK. A miss holds all outputs.
REQ-020 ACQUIRE: each hit loads directly and increments hit count; reaching ACQ_FRAMES moves to TRACK. A miss clears the count and returns to IDLE.
REQ-021 TRACK: a hit applies the EMA to each of x, y, w and h. A miss holds the outputs, sets miss count to 1 and moves to COAST.
REQ-022 COAST: a hit applies the EMA, clears the miss count and returns to TRACK. A miss increments the miss count; reaching LOST_FRAMES moves to IDLE with outputs held.
REQ-023 EMA arithmetic: 12-bit signed difference, arithmetic right shift (truncation toward minus infinity), result clamped to 0..2^width-1. No overflow or wrap is permitted.
REQ-024 Frames without valid_in change no state.

Configuration
REQ-025 With BOX_TRACKER_JUMP_REJECT_EN defined: in TRACK/COAST, a hit whose centre (x+(w>>1), y+(h>>1)) differs from the smoothed centre by more than MAX_JUMP on either axis is treated as a miss. Without the macro: no jump check, and MAX_JUMP is unused.

Reset
REQ-026 rst_n_in low: asynchronously clears state to IDLE, all outputs, both counters and the pipeline valid bits to 0.
REQ-027 A reset asserted mid-pipeline discards the in-flight measurement; no update_out follows release.
REQ-028 After release, the first valid_in is processed normally.

Structure
REQ-029 Package box_pkg holds the state enum, coordinate width localparams (X_W=11, Y_W=10) and a box_t struct {x,y,w,h}.
REQ-030 One sub-module, ema_update (parameterised width and SHIFT), is instantiated four times; it holds the difference, shift and clamp logic.

Verification
REQ-031 Three hits with x=100, y=100, w=40, h=40 -> locked_out rises with the third update_out; outputs 100/100/40/40; state_out=2.
REQ-032 Locked, then a hit with x=140 and other fields unchanged -> x_out=110, y/w/h unchanged.
REQ-033 Locked, then w=7, h=9 (area 63) -> treated as miss, state_out=3, outputs held. Seven further misses -> state_out=0, locked_out=0.
REQ-034 Locked at x_out=110, then a hit with x=400: with the macro -> miss, state COAST, x_out=110; without the macro -> x_out=182.
REQ-035 rst_n_in pulsed low one cycle after a valid_in -> no update_out, all outputs 0, state_out=0.
REQ-036 valid_in high on 4 consecutive cycles, each a hit -> 4 consecutive update_out pulses, lock on the third.

Source files
------------

// File: rtl/box_tracker_pkg.sv
// Shared types for the box tracker: tracker state encoding, coordinate widths
// and the packed bounding-box record used throughout the pipeline.
package box_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_COAST   = 2'd3
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
  } box_t;

endpackage

// File: rtl/box_tracker_ema_update.sv
// One-axis exponential smoothing step: old + (meas - old) >>> SHIFT, with the
// result clamped into the unsigned range of the coordinate.
module ema_update #(
  parameter int W     = 11,
  parameter int SHIFT = 2
) (
  input  logic [W-1:0] old_val,
  input  logic [W-1:0] meas,
  output logic [W-1:0] new_val
);

  localparam int DW = 12;
  localparam logic signed [DW:0] MAX_V = (DW+1)'((1 << W) - 1);

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] step;
  logic signed [DW:0]   sum;

  function automatic logic [W-1:0] clamp(input logic signed [DW:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_V)
      return '1;
    else
      return v[W-1:0];
  endfunction

  // Arithmetic shift floors toward minus infinity, so a downward move of
  // less than 2^SHIFT still steps by one.
  always_comb begin
    diff    = $signed(DW'(meas)) - $signed(DW'(old_val));
    step    = diff >>> SHIFT;
    sum     = $signed({step[DW-1], step}) + $signed((DW+1)'(old_val));
    new_val = clamp(sum);
  end

endmodule

// File: rtl/box_tracker.sv
// Two-stage bounding-box tracker: stage 1 qualifies the measurement by area,
// stage 2 runs the acquire/track/coast FSM and EMA-smooths the box.
// Optional macro BOX_TRACKER_JUMP_REJECT_EN rejects large centre jumps while locked.
module box_tracker
  import box_pkg::*;
#(
  parameter int SHIFT       = 2,
  parameter int MIN_AREA    = 64,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int MAX_JUMP    = 128
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [X_W-1:0] w_in,
  input  logic [Y_W-1:0] h_in,
  input  logic           valid_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [X_W-1:0] w_out,
  output logic [Y_W-1:0] h_out,
  output logic           locked_out,
  output logic           update_out,
  output logic [1:0]     state_out
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] ACQ_N    = CNT_W'(ACQ_FRAMES);
  localparam logic [CNT_W-1:0] LOST_N   = CNT_W'(LOST_FRAMES);
  localparam logic [20:0]      AREA_MIN = 21'(MIN_AREA);

  logic [20:0]      area;
  logic             vld_p1;
  logic             hit_p1;
  box_t             meas_p1;

  box_t             box_p2;
  box_t             ema_box;
  state_t           state_p2;
  logic [CNT_W-1:0] hit_cnt_p2;
  logic [CNT_W-1:0] miss_cnt_p2;
  logic             locked_p2;
  logic             update_p2;
  logic             trk_hit;

  assign area = 21'(w_in) * 21'(h_in);

  // ---- stage 1: register measurement, qualify by area ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= valid_in;
  end

  always_ff @(posedge clk_in) begin
    meas_p1 <= '{x: x_in, y: y_in, w: w_in, h: h_in};
    hit_p1  <= (w_in != '0) && (area >= AREA_MIN);
  end

  ema_update #(.W(X_W), .SHIFT(SHIFT)) u_ema_x (
    .old_val(box_p2.x), .meas(meas_p1.x), .new_val(ema_box.x)
  );
  ema_update #(.W(Y_W), .SHIFT(SHIFT)) u_ema_y (
    .old_val(box_p2.y), .meas(meas_p1.y), .new_val(ema_box.y)
  );
  ema_update #(.W(X_W), .SHIFT(SHIFT)) u_ema_w (
    .old_val(box_p2.w), .meas(meas_p1.w), .new_val(ema_box.w)
  );
  ema_update #(.W(Y_W), .SHIFT(SHIFT)) u_ema_h (
    .old_val(box_p2.h), .meas(meas_p1.h), .new_val(ema_box.h)
  );

`ifdef BOX_TRACKER_JUMP_REJECT_EN
  localparam logic signed [X_W+1:0] JUMP_X = (X_W+2)'(MAX_JUMP);
  localparam logic signed [Y_W+1:0] JUMP_Y = (Y_W+2)'(MAX_JUMP);

  logic [X_W:0]          cx_meas, cx_box;
  logic [Y_W:0]          cy_meas, cy_box;
  logic signed [X_W+1:0] dx;
  logic signed [Y_W+1:0] dy;
  logic                  jump_far;

  // Centres are compared against the smoothed box, not the last raw input.
  always_comb begin
    cx_meas  = (X_W+1)'(meas_p1.x) + (X_W+1)'(meas_p1.w >> 1);
    cx_box   = (X_W+1)'(box_p2.x)  + (X_W+1)'(box_p2.w >> 1);
    cy_meas  = (Y_W+1)'(meas_p1.y) + (Y_W+1)'(meas_p1.h >> 1);
    cy_box   = (Y_W+1)'(box_p2.y)  + (Y_W+1)'(box_p2.h >> 1);
    dx       = $signed({1'b0, cx_meas}) - $signed({1'b0, cx_box});
    dy       = $signed({1'b0, cy_meas}) - $signed({1'b0, cy_box});
    jump_far = (dx > JUMP_X) || (dx < -JUMP_X) || (dy > JUMP_Y) || (dy < -JUMP_Y);
    trk_hit  = hit_p1 && !jump_far;
  end
`else
  assign trk_hit = hit_p1;
`endif

  // ---- stage 2: tracking FSM and smoothed box ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_p2    <= ST_IDLE;
      box_p2      <= '0;
      hit_cnt_p2  <= '0;
      miss_cnt_p2 <= '0;
      locked_p2   <= 1'b0;
      update_p2   <= 1'b0;
    end else begin
      update_p2 <= vld_p1;
      if (vld_p1) begin
        case (state_p2)
          ST_IDLE: begin
            if (hit_p1) begin
              box_p2     <= meas_p1;
              hit_cnt_p2 <= CNT_W'(1);
              if (ACQ_N <= CNT_W'(1)) begin
                state_p2  <= ST_TRACK;
                locked_p2 <= 1'b1;
              end else begin
                state_p2 <= ST_ACQUIRE;
              end
            end
          end
          ST_ACQUIRE: begin
            if (hit_p1) begin
              box_p2     <= meas_p1;
              hit_cnt_p2 <= hit_cnt_p2 + CNT_W'(1);
              if (hit_cnt_p2 + CNT_W'(1) >= ACQ_N) begin
                state_p2  <= ST_TRACK;
                locked_p2 <= 1'b1;
              end
            end else begin
              hit_cnt_p2 <= '0;
              state_p2   <= ST_IDLE;
            end
          end
          ST_TRACK: begin
            if (trk_hit) begin
              box_p2 <= ema_box;
            end else if (LOST_N <= CNT_W'(1)) begin
              state_p2    <= ST_IDLE;
              locked_p2   <= 1'b0;
              hit_cnt_p2  <= '0;
              miss_cnt_p2 <= '0;
            end else begin
              miss_cnt_p2 <= CNT_W'(1);
              state_p2    <= ST_COAST;
            end
          end
          ST_COAST: begin
            if (trk_hit) begin
              box_p2      <= ema_box;
              miss_cnt_p2 <= '0;
              state_p2    <= ST_TRACK;
            end else if (miss_cnt_p2 + CNT_W'(1) >= LOST_N) begin
              state_p2    <= ST_IDLE;
              locked_p2   <= 1'b0;
              hit_cnt_p2  <= '0;
              miss_cnt_p2 <= '0;
            end else begin
              miss_cnt_p2 <= miss_cnt_p2 + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign x_out      = box_p2.x;
  assign y_out      = box_p2.y;
  assign w_out      = box_p2.w;
  assign h_out      = box_p2.h;
  assign locked_out = locked_p2;
  assign update_out = update_p2;
  assign state_out  = state_p2;

endmodule

// File: tb/tb_box_tracker.sv
// Directed bench for box_tracker: acquisition, EMA smoothing, coasting/drop,
// area threshold, back-to-back frames, jump handling and mid-pipeline reset.
module tb_box_tracker;
  import box_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [X_W-1:0] x_in, w_in, x_out, w_out;
  logic [Y_W-1:0] y_in, h_in, y_out, h_out;
  logic           valid_in, locked_out, update_out;
  logic [1:0]     state_out;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  box_tracker dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .valid_in  (valid_in),
    .x_out     (x_out),
    .y_out     (y_out),
    .w_out     (w_out),
    .h_out     (h_out),
    .locked_out(locked_out),
    .update_out(update_out),
    .state_out (state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_box(input string tag, input int x, input int y, input int w, input int h);
    chk({tag, ".x"}, 32'(x_out), 32'(x));
    chk({tag, ".y"}, 32'(y_out), 32'(y));
    chk({tag, ".w"}, 32'(w_out), 32'(w));
    chk({tag, ".h"}, 32'(h_out), 32'(h));
  endtask

  task automatic chk_ctl(input string tag, input int upd, input int st, input int lk);
    chk({tag, ".upd"}, 32'(update_out), 32'(upd));
    chk({tag, ".state"}, 32'(state_out), 32'(st));
    chk({tag, ".locked"}, 32'(locked_out), 32'(lk));
  endtask

  task automatic set_meas(input int x, input int y, input int w, input int h);
    x_in = X_W'(x);
    y_in = Y_W'(y);
    w_in = X_W'(w);
    h_in = Y_W'(h);
  endtask

  // Returns on the falling edge where the resulting update_out is visible.
  task automatic frame(input int x, input int y, input int w, input int h);
    @(negedge clk);
    set_meas(x, y, w, h);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    set_meas(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_ctl("reset", 0, 0, 0);
    chk_box("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Acquire over three identical hits
    frame(100, 100, 40, 40);
    chk_ctl("acq1", 1, 1, 0);
    chk_box("acq1", 100, 100, 40, 40);
    frame(100, 100, 40, 40);
    chk_ctl("acq2", 1, 1, 0);
    frame(100, 100, 40, 40);
    chk_ctl("acq3", 1, 2, 1);
    chk_box("acq3", 100, 100, 40, 40);
    @(negedge clk);
    chk("acq3.pulse_end", 32'(update_out), 0);

    // EMA toward x=140: 100 + (40 >>> 2) = 110
    frame(140, 100, 40, 40);
    chk_ctl("ema_up", 1, 2, 1);
    chk_box("ema_up", 110, 100, 40, 40);

    // Area 63 is a miss -> coast, box held
    frame(110, 100, 7, 9);
    chk_ctl("area63", 1, 3, 1);
    chk_box("area63", 110, 100, 40, 40);
    for (int i = 0; i < 6; i++) frame(0, 0, 0, 0);
    chk_ctl("coast7", 1, 3, 1);
    frame(0, 0, 0, 0);
    chk_ctl("lost", 1, 0, 0);
    chk_box("lost", 110, 100, 40, 40);

    // Miss in IDLE holds everything
    frame(0, 0, 0, 0);
    chk_ctl("idle_miss", 1, 0, 0);
    chk_box("idle_miss", 110, 100, 40, 40);

    // Area exactly 64 is a hit
    frame(5, 6, 8, 8);
    chk_ctl("area64", 1, 1, 0);
    chk_box("area64", 5, 6, 8, 8);

    // Miss during acquire returns to IDLE
    frame(110, 100, 7, 9);
    chk_ctl("acq_miss", 1, 0, 0);
    chk_box("acq_miss", 5, 6, 8, 8);

    // Four back-to-back hits: four pulses, lock on the third
    @(negedge clk);
    set_meas(110, 100, 40, 40);
    valid_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_ctl("b2b1", 1, 1, 0);
    @(negedge clk);
    chk_ctl("b2b2", 1, 1, 0);
    @(negedge clk);
    valid_in = 1'b0;
    chk_ctl("b2b3", 1, 2, 1);
    @(negedge clk);
    chk_ctl("b2b4", 1, 2, 1);
    chk_box("b2b4", 110, 100, 40, 40);
    @(negedge clk);
    chk("b2b.idle", 32'(update_out), 0);

    // Downward EMA floors: 100 + (-13 >>> 2) = 100 - 4 = 96
    frame(110, 87, 40, 40);
    chk_ctl("ema_down", 1, 2, 1);
    chk_box("ema_down", 110, 96, 40, 40);

    // Large jump in x
    frame(400, 96, 40, 40);
`ifdef BOX_TRACKER_JUMP_REJECT_EN
    chk_ctl("jump", 1, 3, 1);
    chk_box("jump", 110, 96, 40, 40);
`else
    chk_ctl("jump", 1, 2, 1);
    chk_box("jump", 182, 96, 40, 40);
`endif

    // Reset while a measurement sits in stage 1
    @(negedge clk);
    set_meas(100, 100, 40, 40);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_ctl("rst_mid", 0, 0, 0);
    chk_box("rst_mid", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ctl("rst_rel1", 0, 0, 0);
    @(negedge clk);
    chk_ctl("rst_rel2", 0, 0, 0);
    chk_box("rst_rel2", 0, 0, 0, 0);

    // First frame after release is processed normally
    frame(100, 100, 40, 40);
    chk_ctl("post_rst", 1, 1, 0);
    chk_box("post_rst", 100, 100, 40, 40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
